// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt aggregator between SoC peripherals and the core.
// Latches peripheral requests into pending bits (edge or level per source),
// masks them with an enable register and drives a registered irq line plus
// the id of the lowest-index enabled pending source. Memory-mapped on the
// core data bus with req/gnt/rvalid timing.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   irq_src  peripheral requests (bit 0 = timer), synchronous to clk
//   req      bus request
//   we       write enable, qualified by req
//   addr     byte address, addr[4:2] decoded
//   wdata    write data
//   gnt      bus grant, combinational copy of req
//   rvalid   response valid, one cycle after each granted req
//   rdata    registered read data, held between reads
//   err      bus error, always 0
//   irq      registered interrupt request to core
//   irq_id   registered index of the winning source
//
// Register map (word offsets):
//   0x00 IER   RW    enable mask
//   0x04 IPR   RW1C  pending bits (W1C affects edge-mode bits only)
//   0x08 CFG   RW    1 = edge, 0 = level
//   0x0C CLAIM RO    bit31 = valid, [ID_W-1:0] = id; clears edge pending
//   0x10 RAW   RO    current irq_src
//   0x14..0x1C       read 0, writes ignored

module irq_ctrl #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               req,
    input  logic               we,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               gnt,
    output logic               rvalid,
    output logic [31:0]        rdata,
    output logic               err,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 3;

    localparam logic [OFF_W-1:0] OFF_IER   = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_IPR   = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_CFG   = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_CLAIM = OFF_W'(3);
    localparam logic [OFF_W-1:0] OFF_RAW   = OFF_W'(4);

    // Architectural state
    logic [NUM_IRQ-1:0] ier_q;
    logic [NUM_IRQ-1:0] ipr_q;
    logic [NUM_IRQ-1:0] cfg_q;
    logic [NUM_IRQ-1:0] src_q;

    // Combinational helpers
    logic [OFF_W-1:0]   off_c;
    logic               bus_wr_c;
    logic               bus_rd_c;
    logic [NUM_IRQ-1:0] pend_c;
    logic               prio_valid_c;
    logic [ID_W-1:0]    prio_id_c;
    logic [NUM_IRQ-1:0] rise_c;
    logic [NUM_IRQ-1:0] w1c_c;
    logic [NUM_IRQ-1:0] claim_clr_c;
    logic [NUM_IRQ-1:0] ipr_nxt_c;
    logic [DATA_W-1:0]  claim_word_c;
    logic [DATA_W-1:0]  rd_data_c;
    logic               unused_bits;

    // Bus side: grant is immediate, no error responses
    assign gnt = req;
    assign err = 1'b0;

    assign off_c    = addr[4:2];
    assign bus_wr_c = req & we;
    assign bus_rd_c = req & ~we;

    assign unused_bits = ^{addr[31:5], addr[1:0], wdata};

    // Lowest enabled pending index wins; none pending gives id 0, valid 0
    assign pend_c = ipr_q & ier_q;

    always_comb begin
        prio_valid_c = 1'b0;
        prio_id_c    = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (pend_c[i] && !prio_valid_c) begin
                prio_valid_c = 1'b1;
                prio_id_c    = ID_W'(i);
            end
        end
    end

    // Pending update: edge bits set on rise (set beats clear), level bits track source
    assign rise_c = irq_src & ~src_q;

    always_comb begin
        w1c_c       = '0;
        claim_clr_c = '0;
        if (bus_wr_c && off_c == OFF_IPR) begin
            w1c_c = wdata[NUM_IRQ-1:0];
        end
        if (bus_rd_c && off_c == OFF_CLAIM && prio_valid_c) begin
            claim_clr_c = NUM_IRQ'(1) << prio_id_c;
        end
        ipr_nxt_c = (cfg_q & ((ipr_q & ~(w1c_c | claim_clr_c)) | rise_c))
                  | (~cfg_q & irq_src);
    end

    // Read data mux; CLAIM sees the same-cycle priority result
    always_comb begin
        claim_word_c                = '0;
        claim_word_c[ID_W-1:0]      = prio_id_c;
        claim_word_c[DATA_W-1]      = prio_valid_c;
        rd_data_c                   = '0;
        case (off_c)
            OFF_IER:   rd_data_c = DATA_W'(ier_q);
            OFF_IPR:   rd_data_c = DATA_W'(ipr_q);
            OFF_CFG:   rd_data_c = DATA_W'(cfg_q);
            OFF_CLAIM: rd_data_c = claim_word_c;
            OFF_RAW:   rd_data_c = DATA_W'(irq_src);
            default:   rd_data_c = '0;
        endcase
    end

    // Register state, bus response and core-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ier_q  <= '0;
            ipr_q  <= '0;
            cfg_q  <= '0;
            src_q  <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            src_q <= irq_src;
            ipr_q <= ipr_nxt_c;
            if (bus_wr_c && off_c == OFF_IER) begin
                ier_q <= wdata[NUM_IRQ-1:0];
            end
            if (bus_wr_c && off_c == OFF_CFG) begin
                cfg_q <= wdata[NUM_IRQ-1:0];
            end
            rvalid <= req;
            if (bus_rd_c) begin
                rdata <= rd_data_c;
            end
            irq    <= prio_valid_c;
            irq_id <= prio_id_c;
        end
    end

endmodule
